// File: rtl/ram_fifo_pkg.sv
// Shared constants and grant encoding for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic {
    GRANT_PUSH = 1'b0,
    GRANT_POP  = 1'b1
  } grant_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for the single shared RAM port: push vs pop.
module ram_port_arbiter
  import ram_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push_elig,
  input  logic pop_elig,
  output logic push_grant,
  output logic pop_grant
);

  grant_t last_grant_r;
  logic   contest_s;

  // Grant selection; a contest goes to the side that lost the previous contest.
  always_comb begin
    push_grant = 1'b0;
    pop_grant  = 1'b0;
    contest_s  = push_elig & pop_elig;
    if (rst) begin
      push_grant = 1'b0;
      pop_grant  = 1'b0;
    end else if (contest_s) begin
      case (last_grant_r)
        GRANT_POP:  push_grant = 1'b1;
        GRANT_PUSH: pop_grant  = 1'b1;
        default:    push_grant = 1'b1;
      endcase
    end else begin
      push_grant = push_elig;
      pop_grant  = pop_elig;
    end
  end

  // Remember the contest winner; uncontested grants leave the history alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= GRANT_POP;
    end else if (contest_s) begin
      last_grant_r <= push_grant ? GRANT_PUSH : GRANT_POP;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// 16-deep FIFO controller driving a single-port RAM; one RAM access per cycle.
module ram_fifo_ctrl #(
  parameter int DATA_W = ram_fifo_pkg::DATA_W,
  parameter int ADDR_W = ram_fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ack,
  input  logic              pop_req,
  output logic              pop_ack,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              push_elig_s;
  logic              pop_elig_s;

  assign push_elig_s = push_valid & ~full;
  assign pop_elig_s  = pop_req & ~empty;

  ram_port_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .push_elig  (push_elig_s),
    .pop_elig   (pop_elig_s),
    .push_grant (push_ack),
    .pop_grant  (pop_ack)
  );

  // RAM port drive; the address idles on rd_ptr so a pop needs no setup.
  assign mem_wr_en   = push_ack;
  assign mem_rd_en   = pop_ack;
  assign mem_data_in = push_data;
  assign mem_address = push_ack ? wr_ptr_r : rd_ptr_r;

  // Next occupancy; grants are exclusive so count moves by at most one.
  always_comb begin
    count_nxt_s = count;
    case ({push_ack, pop_ack})
      2'b10:   count_nxt_s = count + CNT_W'(1);
      2'b01:   count_nxt_s = count - CNT_W'(1);
      default: count_nxt_s = count;
    endcase
  end

  // Pointers, occupancy flags and the dequeued-word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= {ADDR_W{1'b0}};
      rd_ptr_r  <= {ADDR_W{1'b0}};
      count     <= {CNT_W{1'b0}};
      full      <= 1'b0;
      empty     <= 1'b1;
      pop_valid <= 1'b0;
      pop_data  <= {DATA_W{1'b0}};
    end else begin
      wr_ptr_r  <= push_ack ? wr_ptr_r + ADDR_W'(1) : wr_ptr_r;
      rd_ptr_r  <= pop_ack ? rd_ptr_r + ADDR_W'(1) : rd_ptr_r;
      // RAM read data is captured only in the accepting cycle.
      pop_data  <= pop_ack ? mem_data_out : pop_data;
      pop_valid <= pop_ack;
      count     <= count_nxt_s;
      full      <= (count_nxt_s == CNT_W'(DEPTH));
      empty     <= (count_nxt_s == {CNT_W{1'b0}});
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: directed scenarios then random traffic vs a queue model.
module tb_ram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid;
  logic [15:0] push_data;
  logic        push_ack;
  logic        pop_req;
  logic        pop_ack;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [3:0]  mem_address;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;

  logic [15:0] ram [16];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [15:0] q [$];
  int          n_pushed;
  int          n_popped;
  bit          last_was_pop;
  logic [15:0] exp_pop_data;
  bit          exp_pop_valid;

  always #5 clk = ~clk;

  // behavioural 16x16 RAM: synchronous write, combinational read
  always @(posedge clk) if (mem_wr_en) ram[mem_address] <= mem_data_in;
  assign mem_data_out = ram[mem_address];

  ram_fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ack     (push_ack),
    .pop_req      (pop_req),
    .pop_ack      (pop_ack),
    .pop_data     (pop_data),
    .pop_valid    (pop_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .mem_wr_en    (mem_wr_en),
    .mem_rd_en    (mem_rd_en),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // one clock cycle: drive, check combinational outputs mid-cycle, advance model, check registers
  task automatic cycle(input logic pv, input logic [15:0] pd, input logic pr, input logic r,
                       input string tag);
    bit pe, qe, gp, gq;
    int sz;
    push_valid = pv;
    push_data  = pd;
    pop_req    = pr;
    rst        = r;
    @(negedge clk);
    sz = q.size();
    pe = pv && (sz < 16);
    qe = pr && (sz > 0);
    gp = 1'b0;
    gq = 1'b0;
    if (!r) begin
      if (pe && qe) begin
        gp = last_was_pop;
        gq = !last_was_pop;
        last_was_pop = gq;
      end else begin
        gp = pe;
        gq = qe;
      end
    end
    check({tag, ".push_ack"}, push_ack, gp);
    check({tag, ".pop_ack"}, pop_ack, gq);
    check({tag, ".mem_wr_en"}, mem_wr_en, gp);
    check({tag, ".mem_rd_en"}, mem_rd_en, gq);
    if (!r) begin
      check({tag, ".mem_address"}, mem_address, gp ? (n_pushed % 16) : (n_popped % 16));
      check({tag, ".mem_data_in"}, mem_data_in, pd);
    end
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      n_pushed      = 0;
      n_popped      = 0;
      last_was_pop  = 1'b1;
      exp_pop_valid = 1'b0;
      exp_pop_data  = 16'h0000;
    end else begin
      if (gp) begin
        q.push_back(pd);
        n_pushed++;
      end
      if (gq) begin
        exp_pop_data = q.pop_front();
        n_popped++;
      end
      exp_pop_valid = gq;
    end
    check({tag, ".pop_valid"}, pop_valid, exp_pop_valid);
    check({tag, ".pop_data"}, pop_data, exp_pop_data);
    check({tag, ".count"}, count, q.size());
    check({tag, ".full"}, full, q.size() == 16);
    check({tag, ".empty"}, empty, q.size() == 0);
  endtask

  initial begin
    push_valid    = 1'b0;
    push_data     = 16'h0000;
    pop_req       = 1'b0;
    rst           = 1'b1;
    n_pushed      = 0;
    n_popped      = 0;
    last_was_pop  = 1'b1;
    exp_pop_data  = 16'h0000;
    exp_pop_valid = 1'b0;

    cycle(1'b0, 16'h0000, 1'b1, 1'b1, "reset");
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, "idle");

    // single word round trip
    cycle(1'b1, 16'hA5A5, 1'b0, 1'b0, "single_push");
    check("single_push.count_is_1", count, 5'd1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, "single_pop");
    check("single_pop.data", pop_data, 16'hA5A5);
    check("single_pop.empty", empty, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, "single_idle");

    // fill to full, overflow attempt, drain in order
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0, "fill");
    check("fill.full", full, 1'b1);
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0, "push_full");
    check("push_full.count", count, 5'd16);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 16'h0000, 1'b1, 1'b0, "drain");
      check("drain.order", pop_data, 16'(i));
    end
    check("drain.empty", empty, 1'b1);

    // pop on empty
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, "pop_empty");

    // contested access alternates, starting with push after reset history
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, "pre4");
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h3000 + 16'(i), 1'b1, 1'b0, "contest");
    check("contest.count_end", count, 5'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, "contest_drain");

    // pointer wrap with interleaved pairs
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, "wrap_push");
      cycle(1'b0, 16'h0000, 1'b1, 1'b0, "wrap_pop");
      check("wrap.seq", pop_data, 16'h1000 + 16'(i));
    end

    // reset mid-operation with pop requested
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b0, "pre_rst");
    cycle(1'b0, 16'h0000, 1'b1, 1'b1, "mid_rst");
    check("mid_rst.count", count, 5'd0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, "post_rst_pop");
    check("post_rst_pop.no_valid", pop_valid, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 16'($urandom), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 2), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
